shared_adder_arbiter: RTL

Shares one WIDTH-bit ripple adder datapath (addern-style: a + b + cin -> sum, cout, signed overflow) between N_REQ requesters. Round-robin arbitration picks at most one operation per cycle. Valid/ready handshakes on both the request and response sides. A single registered output stage gives 1-cycle latency at full throughput. Sits between several client blocks and the adder resource, replacing per-client adder instances.

---
 rtl/shared_adder_arbiter_pkg.sv | 17 +
 rtl/shared_adder_arbiter_rr_arbiter.sv | 50 +++++
 rtl/shared_adder_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/shared_adder_arbiter_pkg.sv
// Shared constants and helpers for the shared adder arbiter slice.
package shared_adder_arbiter_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N_REQ = 4;
    localparam int STAT_W    = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/shared_adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting after the last granted index.
module rr_arbiter
    import shared_adder_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = clog2(DEF_N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    logic [ID_W-1:0]  last_grant;
    logic [N_REQ-1:0] upper;
    logic [N_REQ-1:0] upper_first;
    logic [N_REQ-1:0] req_first;

    // Requests above the pointer win; otherwise wrap to the lowest request.
    always_comb begin
        upper = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            upper[i] = req[i] && (32'(last_grant) < i);
        end
    end

    assign upper_first = upper & (~upper + N_REQ'(1));
    assign req_first   = req & (~req + N_REQ'(1));
    assign grant       = !advance ? '0 : ((|upper) ? upper_first : req_first);

    always_comb begin
        grant_id = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_id = grant_id | ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= ID_W'(N_REQ - 1);
        end else if (|grant) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/shared_adder_arbiter.sv
// One ripple adder shared by N_REQ requesters with a registered result stage.
// Optional statistics counters are enabled by defining SHARED_ADDER_STATS_EN.
module shared_adder_arbiter
    import shared_adder_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ID_W  = clog2(DEF_N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef SHARED_ADDER_STATS_EN
    input  logic                   stat_clr,
    output logic [STAT_W-1:0]      stat_ops,
    output logic [STAT_W-1:0]      stat_ovf,
`endif
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_ovf
);

    if (ID_W != clog2(N_REQ) || N_REQ < 2 || N_REQ > 8 || WIDTH < 2) begin : g_param_check
        $error("shared_adder_arbiter: bad parameters (ID_W must equal clog2(N_REQ))");
    end

    logic              accept;
    logic              advance;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_id;
    logic              granted;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic              sel_cin;
    logic [WIDTH-1:0]  sum;
    logic              carry;
    logic              ovf;

    assign accept  = !rsp_valid || rsp_ready;
    assign advance = accept && !rst;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .advance  (advance),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;
    assign granted   = |grant;

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a   = req_a[i*WIDTH +: WIDTH];
                sel_b   = req_b[i*WIDTH +: WIDTH];
                sel_cin = req_cin[i];
            end
        end
    end

    always_comb begin
        carry = sel_cin;
        sum   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i] = sel_a[i] ^ sel_b[i] ^ carry;
            carry  = (sel_a[i] & sel_b[i]) | (carry & (sel_a[i] ^ sel_b[i]));
        end
    end

    assign ovf = (sel_a[WIDTH-1] == sel_b[WIDTH-1]) && (sum[WIDTH-1] != sel_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else if (granted) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant_id;
            rsp_sum   <= sum;
            rsp_cout  <= carry;
            rsp_ovf   <= ovf;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef SHARED_ADDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else if (granted) begin
            stat_ops <= stat_ops + 1'b1;
            if (ovf) begin
                stat_ovf <= stat_ovf + 1'b1;
            end
        end
    end
`endif

endmodule
